// File: rtl/iob_uart_bridge.sv
// rtl/iob_uart_bridge.sv - UART 8N1 command port that issues IOb writes/reads and returns ACK or read data
// Optional partial-frame timeout: define IOB_UART_BRIDGE_TIMEOUT_EN.
module iob_uart_bridge #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int BAUD_DIV = 868
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                rxd_i,
  output logic                txd_o,
  output logic                iob_valid_o,
  output logic [ADDR_W-1:0]   iob_addr_o,
  output logic [DATA_W-1:0]   iob_wdata_o,
  output logic [DATA_W/8-1:0] iob_wstrb_o,
  input  logic                iob_ready_i,
  input  logic                iob_rvalid_i,
  input  logic [DATA_W-1:0]   iob_rdata_i,
  output logic                busy_o
);
  localparam logic [15:0] BIT_LEN  = 16'(BAUD_DIV - 1);
  localparam logic [15:0] HALF_LEN = 16'(BAUD_DIV / 2 - 1);
  localparam logic [7:0]  CMD_W    = 8'h57;
  localparam logic [7:0]  CMD_R    = 8'h52;
  localparam logic [7:0]  ACK      = 8'h06;

  typedef enum logic [2:0] {IDLE, ADDR, WDATA, REQ, WAIT_RD, RESP} state_t;
  state_t state, state_nx;

  logic        rx_meta, rx_sync, rx_prev;
  logic        rx_active;
  logic [15:0] rx_cnt;
  logic [3:0]  rx_bit;
  logic [7:0]  rx_shift;
  logic        rx_strb;
  logic [7:0]  rx_byte;

  logic        tx_active;
  logic [15:0] tx_cnt;
  logic [3:0]  tx_bit;
  logic [9:0]  tx_shift;
  logic        tx_load, tx_done;

  logic        is_write;
  logic [1:0]  byte_cnt;
  logic [31:0] addr_q, wdata_q, resp_word;
  logic [2:0]  resp_left;
  logic        to_hit;

  // rx_bit: 0 = start, 1..8 = data, 9 = stop
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      rx_meta   <= 1'b1;
      rx_sync   <= 1'b1;
      rx_prev   <= 1'b1;
      rx_active <= 1'b0;
      rx_cnt    <= '0;
      rx_bit    <= '0;
      rx_shift  <= '0;
      rx_strb   <= 1'b0;
      rx_byte   <= '0;
    end else begin
      rx_meta <= rxd_i;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
      rx_strb <= 1'b0;
      if (!rx_active) begin
        if (rx_prev && !rx_sync) begin
          rx_active <= 1'b1;
          rx_cnt    <= HALF_LEN;
          rx_bit    <= '0;
        end
      end else if (rx_cnt != 16'd0) begin
        rx_cnt <= rx_cnt - 16'd1;
      end else begin
        rx_cnt <= BIT_LEN;
        rx_bit <= rx_bit + 4'd1;
        if (rx_bit == 4'd0) begin
          if (rx_sync) rx_active <= 1'b0;
        end else if (rx_bit == 4'd9) begin
          rx_active <= 1'b0;
          if (rx_sync) begin
            rx_strb <= 1'b1;
            rx_byte <= rx_shift;
          end
        end else begin
          rx_shift <= {rx_sync, rx_shift[7:1]};
        end
      end
    end
  end

  // Reloading on the last stop-bit cycle keeps response bytes gapless
  assign tx_done = tx_active && (tx_cnt == 16'd0) && (tx_bit == 4'd9);
  assign tx_load = (state == RESP) && (resp_left != 3'd0) && (!tx_active || tx_done);

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      tx_active <= 1'b0;
      tx_cnt    <= '0;
      tx_bit    <= '0;
      tx_shift  <= '1;
    end else if (tx_load) begin
      tx_active <= 1'b1;
      tx_cnt    <= BIT_LEN;
      tx_bit    <= '0;
      tx_shift  <= {1'b1, resp_word[7:0], 1'b0};
    end else if (tx_active) begin
      if (tx_cnt != 16'd0) begin
        tx_cnt <= tx_cnt - 16'd1;
      end else if (tx_bit == 4'd9) begin
        tx_active <= 1'b0;
      end else begin
        tx_cnt   <= BIT_LEN;
        tx_bit   <= tx_bit + 4'd1;
        tx_shift <= {1'b1, tx_shift[9:1]};
      end
    end
  end

  assign txd_o = !tx_active || tx_shift[0];

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      is_write  <= 1'b0;
      byte_cnt  <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      resp_word <= '0;
      resp_left <= '0;
    end else begin
      if (state == IDLE) begin
        byte_cnt <= '0;
        if (rx_strb) is_write <= (rx_byte == CMD_W);
      end else if (rx_strb && (state == ADDR || state == WDATA)) begin
        byte_cnt <= byte_cnt + 2'd1;
      end
      if (rx_strb && state == ADDR)  addr_q  <= {rx_byte, addr_q[31:8]};
      if (rx_strb && state == WDATA) wdata_q <= {rx_byte, wdata_q[31:8]};
      if (state == REQ && iob_ready_i) begin
        if (is_write) begin
          resp_word <= {24'h0, ACK};
          resp_left <= 3'd1;
        end else if (iob_rvalid_i) begin
          resp_word <= 32'(iob_rdata_i);
          resp_left <= 3'd4;
        end
      end
      if (state == WAIT_RD && iob_rvalid_i) begin
        resp_word <= 32'(iob_rdata_i);
        resp_left <= 3'd4;
      end
      if (tx_load) begin
        resp_word <= resp_word >> 8;
        resp_left <= resp_left - 3'd1;
      end
    end
  end

`ifdef IOB_UART_BRIDGE_TIMEOUT_EN
  localparam logic [23:0] TO_LAST = 24'(16 * 10 * BAUD_DIV - 1);
  logic [23:0] to_cnt;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i || !(state == ADDR || state == WDATA) || rx_strb) to_cnt <= '0;
    else                                                          to_cnt <= to_cnt + 24'd1;
  end

  assign to_hit = (state == ADDR || state == WDATA) && (to_cnt == TO_LAST);
`else
  assign to_hit = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (rx_strb && (rx_byte == CMD_W || rx_byte == CMD_R)) state_nx = ADDR;
      ADDR: begin
        if (rx_strb && byte_cnt == 2'd3) state_nx = is_write ? WDATA : REQ;
        else if (to_hit)                 state_nx = IDLE;
      end
      WDATA: begin
        if (rx_strb && byte_cnt == 2'd3) state_nx = REQ;
        else if (to_hit)                 state_nx = IDLE;
      end
      REQ:     if (iob_ready_i) state_nx = (is_write || iob_rvalid_i) ? RESP : WAIT_RD;
      WAIT_RD: if (iob_rvalid_i) state_nx = RESP;
      RESP:    if (tx_done && resp_left == 3'd0) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    iob_valid_o = (state == REQ);
    iob_wstrb_o = (state == REQ && is_write) ? '1 : '0;
    iob_addr_o  = ADDR_W'(addr_q);
    iob_wdata_o = DATA_W'(wdata_q);
    busy_o      = (state != IDLE);
  end
endmodule

// File: tb/tb_iob_uart_bridge.sv
// tb/tb_iob_uart_bridge.sv - table-driven bench for iob_uart_bridge at BAUD_DIV=16
// Optional timeout sequence compiled with IOB_UART_BRIDGE_TIMEOUT_EN.
module tb_iob_uart_bridge;
  localparam int BAUD = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rxd;
  logic        txd;
  logic        iob_valid;
  logic [31:0] iob_addr;
  logic [31:0] iob_wdata;
  logic [3:0]  iob_wstrb;
  logic        iob_ready;
  logic        iob_rvalid;
  logic [31:0] iob_rdata;
  logic        busy;

  always #5 clk = ~clk;

  iob_uart_bridge #(.DATA_W(32), .ADDR_W(32), .BAUD_DIV(BAUD)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .rxd_i(rxd), .txd_o(txd),
    .iob_valid_o(iob_valid), .iob_addr_o(iob_addr), .iob_wdata_o(iob_wdata),
    .iob_wstrb_o(iob_wstrb), .iob_ready_i(iob_ready), .iob_rvalid_i(iob_rvalid),
    .iob_rdata_i(iob_rdata), .busy_o(busy)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Serial monitor: decodes txd into bytes and records each start-bit cycle
  logic [7:0] mon_bytes[$];
  int         mon_start[$];
  int         mon_stop_err = 0;
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && txd === 1'b0) begin
        mon_start.push_back(cyc);
        repeat (BAUD / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (BAUD) @(negedge clk);
          b[i] = txd;
        end
        repeat (BAUD) @(negedge clk);
        if (txd !== 1'b1) mon_stop_err++;
        mon_bytes.push_back(b);
      end
    end
  end

  // IOb responder with programmable ready and rvalid latency
  int          ready_delay = 0;
  int          rvalid_delay = 0;
  logic [31:0] rd_value = '0;
  int          vrun = 0, rd_cd = -1, nreq = 0, last_vcycles = 0, unstable = 0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [3:0]  req_wstrb = '0;
  initial begin
    iob_ready = 1'b0; iob_rvalid = 1'b0; iob_rdata = '0;
    forever begin
      @(negedge clk);
      iob_ready = 1'b0;
      iob_rvalid = 1'b0;
      if (rd_cd == 0) begin
        iob_rvalid = 1'b1; iob_rdata = rd_value; rd_cd = -1;
      end else if (rd_cd > 0) begin
        rd_cd--;
      end
      if (iob_valid === 1'b1) begin
        if (vrun == 0) begin
          nreq++; req_addr = iob_addr; req_wdata = iob_wdata; req_wstrb = iob_wstrb;
        end else if (iob_addr !== req_addr || iob_wdata !== req_wdata || iob_wstrb !== req_wstrb) begin
          unstable++;
        end
        vrun++;
        if (vrun == ready_delay + 1) begin
          iob_ready = 1'b1;
          if (iob_wstrb == 4'h0) begin
            if (rvalid_delay == 0) begin
              iob_rvalid = 1'b1; iob_rdata = rd_value;
            end else begin
              rd_cd = rvalid_delay - 1;
            end
          end
        end
      end else if (vrun != 0) begin
        last_vcycles = vrun;
        vrun = 0;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rxd = 1'b0; repeat (BAUD) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i]; repeat (BAUD) @(negedge clk);
    end
    rxd = stop; repeat (BAUD) @(negedge clk);
    rxd = 1'b1; repeat (4) @(negedge clk);
  endtask

  typedef struct {
    int          nbytes;
    logic [71:0] frame;
    logic [8:0]  bad_stop;
    int          ready_delay;
    int          rvalid_delay;
    logic [31:0] rdata;
    int          exp_nreq;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_wstrb;
    int          exp_vcycles;
    int          exp_nresp;
    logic [31:0] exp_resp;
  } vec_t;

  task automatic run_vector(input int idx, input vec_t v);
    int n;
    nreq = 0; last_vcycles = 0; unstable = 0; mon_stop_err = 0;
    mon_bytes.delete(); mon_start.delete();
    ready_delay = v.ready_delay; rvalid_delay = v.rvalid_delay; rd_value = v.rdata;
    for (int i = 0; i < v.nbytes; i++) send_byte(v.frame[8*i +: 8], !v.bad_stop[i]);
    n = 0;
    while ((busy || mon_bytes.size() < v.exp_nresp) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("v%0d finish", idx), (n < 2000) ? 1 : 0, 1);
    repeat (4) @(negedge clk);
    check($sformatf("v%0d nreq", idx), nreq, v.exp_nreq);
    check($sformatf("v%0d addr", idx), req_addr, v.exp_addr);
    check($sformatf("v%0d wstrb", idx), 32'(req_wstrb), 32'(v.exp_wstrb));
    if (v.exp_wstrb == 4'hF) check($sformatf("v%0d wdata", idx), req_wdata, v.exp_wdata);
    check($sformatf("v%0d valid_cycles", idx), last_vcycles, v.exp_vcycles);
    check($sformatf("v%0d req_stable", idx), unstable, 0);
    check($sformatf("v%0d busy_idle", idx), 32'(busy), 0);
    check($sformatf("v%0d nresp", idx), mon_bytes.size(), v.exp_nresp);
    for (int j = 0; j < v.exp_nresp && j < mon_bytes.size(); j++) begin
      check($sformatf("v%0d resp%0d", idx, j), 32'(mon_bytes[j]), 32'(v.exp_resp[8*j +: 8]));
      if (j > 0) check($sformatf("v%0d gap%0d", idx, j), mon_start[j] - mon_start[j-1], 10 * BAUD);
    end
    check($sformatf("v%0d tx_stop", idx), mon_stop_err, 0);
  endtask

  vec_t vecs[6];

  initial begin
    int n;
    logic [39:0] rd_frame;
    vecs[0] = '{9, 72'hDE_AD_BE_EF_80_00_00_10_57, 9'h000, 3, 0, 32'h0,
                1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 4, 1, 32'h0000_0006};
    vecs[1] = '{5, 72'h00_00_00_04_52, 9'h000, 0, 2, 32'h1234_5678,
                1, 32'h0000_0004, 32'h0, 4'h0, 1, 4, 32'h1234_5678};
    vecs[2] = '{8, 72'h00_00_00_00_52_41_FF_00, 9'h000, 1, 0, 32'hCAFE_F00D,
                1, 32'h0000_0000, 32'h0, 4'h0, 2, 4, 32'hCAFE_F00D};
    vecs[3] = '{6, 72'h04_03_02_01_52_52, 9'h001, 0, 1, 32'hA5C3_0F96,
                1, 32'h0403_0201, 32'h0, 4'h0, 1, 4, 32'hA5C3_0F96};
    vecs[4] = '{9, 72'h80_00_00_01_FF_FF_FF_FC_57, 9'h000, 0, 0, 32'h0,
                1, 32'hFFFF_FFFC, 32'h8000_0001, 4'hF, 1, 1, 32'h0000_0006};
    vecs[5] = '{5, 72'h00_00_10_00_52, 9'h000, 2, 5, 32'h00FF_00FF,
                1, 32'h0000_1000, 32'h0, 4'h0, 3, 4, 32'h00FF_00FF};

    rst_n = 1'b0; rxd = 1'b1;
    repeat (3) @(negedge clk);
    check("rst txd", 32'(txd), 1);
    check("rst valid", 32'(iob_valid), 0);
    check("rst busy", 32'(busy), 0);
    check("rst addr", iob_addr, 0);
    check("rst wdata", iob_wdata, 0);
    check("rst wstrb", 32'(iob_wstrb), 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    for (int k = 0; k < 6; k++) run_vector(k, vecs[k]);

    // Reset while a read request waits on a stalled responder
    ready_delay = 100000; nreq = 0;
    rd_frame = 40'h01_00_00_00_52;
    for (int i = 0; i < 5; i++) send_byte(rd_frame[8*i +: 8], 1'b1);
    n = 0;
    while (iob_valid !== 1'b1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("stall valid_seen", (n < 500) ? 1 : 0, 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midreset valid", 32'(iob_valid), 0);
    check("midreset txd", 32'(txd), 1);
    check("midreset busy", 32'(busy), 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    run_vector(6, vecs[4]);

    // Partial frame followed by a long idle line
    nreq = 0;
    send_byte(8'h57, 1'b1);
    send_byte(8'h01, 1'b1);
    repeat (16 * 10 * BAUD + 100) @(negedge clk);
    check("partial nreq", nreq, 0);
`ifdef IOB_UART_BRIDGE_TIMEOUT_EN
    check("timeout busy", 32'(busy), 0);
    run_vector(7, vecs[1]);
`else
    check("partial waits busy", 32'(busy), 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("partial cleared busy", 32'(busy), 0);
    run_vector(7, vecs[1]);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/iob_uart_bridge.md
IOB_UART_BRIDGE -- requirements
Module: iob_uart_bridge

Interface
REQ-001 Parameter DATA_W, default 32, IOb data width; only 32 is supported.
REQ-002 Parameter ADDR_W, default 32, IOb address width.
REQ-003 Parameter BAUD_DIV, default 868, clock cycles per serial bit; legal range 16..65535.
REQ-004 clk_i  in  1  single clock; all logic on the rising edge.
REQ-005 rst_n_i  in  1  reset, synchronous and active-low.
REQ-006 rxd_i  in  1  serial command input, 8N1, idle high.
REQ-007 txd_o  out  1  serial response output, 8N1, idle high.
REQ-008 iob_valid_o  out  1  IOb request valid (initiator side).
REQ-009 iob_addr_o  out  ADDR_W  IOb request address.
REQ-010 iob_wdata_o  out  DATA_W  IOb write data.
REQ-011 iob_wstrb_o  out  DATA_W/8  byte strobes: all ones for a write, zero for a read.
REQ-012 iob_ready_i  in  1  responder accepts the request.
REQ-013 iob_rvalid_i  in  1  read data valid.
REQ-014 iob_rdata_i  in  DATA_W  read data.
REQ-015 busy_o  out  1  high whenever the FSM is not in IDLE.

Function
REQ-016 rxd_i SHALL pass through a 2-flop synchronizer; a falling edge in RX idle starts a frame.
REQ-017 The start bit SHALL be resampled at BAUD_DIV/2 cycles and the frame aborted if high; data bits SHALL be sampled LSB first at each subsequent BAUD_DIV interval.
REQ-018 A stop bit sampled low (framing error) SHALL discard the byte; no byte strobe is issued.
REQ-019 Frame format: command byte, 4 address bytes LSB first, then for writes 4 data bytes LSB first.
REQ-020 Command 0x57 ('W') = write, 0x52 ('R') = read; any other byte in IDLE SHALL be ignored and the FSM stays in IDLE.
REQ-021 FSM states SHALL be IDLE, ADDR, WDATA, REQ, WAIT_RD, RESP.
REQ-022 Transitions SHALL be:
- IDLE -> ADDR on a valid command.
- ADDR -> WDATA (write) or REQ (read) after the 4th address byte.
- WDATA -> REQ after the 4th data byte.
REQ-023 In REQ, iob_valid_o SHALL be high, with address/wdata/wstrb stable, until a cycle with iob_ready_i high; it SHALL deassert the next cycle.
REQ-024 After a write handshake, the FSM SHALL enter RESP and send one byte 0x06.
REQ-025 After a read handshake, the FSM SHALL enter WAIT_RD and capture iob_rdata_i on iob_rvalid_i; rvalid in the same cycle as ready SHALL also be captured.
REQ-026 A read response SHALL be 4 bytes, LSB first.
REQ-027 The TX serializer SHALL send start(0), 8 data bits LSB first, stop(1), each exactly BAUD_DIV cycles.
REQ-028 Bytes in RESP SHALL be sent back-to-back with no idle gap; the FSM returns to IDLE after the final stop bit.
REQ-029 Bytes received outside IDLE/ADDR/WDATA SHALL be dropped.
REQ-030 Bus latency is unbounded: there is no bus timeout.

Reset
REQ-031 While rst_n_i is low at a clock edge, the following SHALL hold:
- txd_o=1, iob_valid_o=0, iob_addr_o=0, iob_wdata_o=0, iob_wstrb_o=0, busy_o=0.
- FSM in IDLE; RX/TX counters and byte counters cleared.
REQ-032 Reset asserted mid-frame or mid-transaction SHALL abort immediately: an in-flight bus request is dropped and a partial TX byte is truncated with the line high.

Configuration
REQ-033 Macro IOB_UART_BRIDGE_TIMEOUT_EN.
REQ-034 When defined: a counter SHALL restart on each received byte in ADDR/WDATA. If it reaches 16*10*BAUD_DIV cycles with no byte, the FSM returns to IDLE, the partial frame is discarded, and no bus request is issued.
REQ-035 When undefined: no timeout logic exists, and a partial frame waits indefinitely.

Verification
REQ-036 BAUD_DIV=16. Send 57 10 00 00 80 EF BE AD DE; responder holds ready low for 3 cycles.
- Required: one request with addr=0x80000010, wdata=0xDEADBEEF, wstrb=0xF.
- Required: valid held for 4 cycles; then txd_o sends 0x06.
REQ-037 Send 52 04 00 00 00; responder gives rvalid 2 cycles after ready with rdata=0x12345678.
- Required: txd_o sends 78 56 34 12 back-to-back.
REQ-038 Send bytes 00 FF 41, then a valid read frame.
- Required: first three bytes are ignored; exactly one read to address 0x00000000 (frame 52 00 00 00 00).
REQ-039 Send 52 with its stop bit driven low, then 52 01 02 03 04.
- Required: first byte discarded; read at 0x04030201.
REQ-040 Assert rst_n_i during REQ with ready low.
- Required: next cycle iob_valid_o=0, txd_o=1, busy_o=0; a following full frame completes normally.
REQ-041 With IOB_UART_BRIDGE_TIMEOUT_EN, send 57 01 then idle for 16*10*BAUD_DIV cycles.
- Required: busy_o falls, no request is issued, and the next frame is decoded from its command byte.
